// File: rtl/fft_mag_streamer_pkg.sv
// Shared definitions for the FFT magnitude streamer: core size defaults
// and the streamer FSM state encoding.
package fft_mag_streamer_pkg;

    localparam int FFT_N   = 16;
    localparam int FFT_MSB = 16;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/fft_mag_streamer_approx.sv
// Alpha-max-beta-min magnitude of one bin word {re, im}, both signed.
// Ports: word (MSB-bit bin word) in, mag (MSB/2-bit unsigned magnitude) out.
module fft_mag_approx
    import fft_mag_streamer_pkg::*;
#(
    parameter int MSB = FFT_MSB,
    localparam int W  = MSB / 2
) (
    input  logic [MSB-1:0] word,
    output logic [W-1:0]   mag
);

    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    // Negating the most negative value wraps back to 2^(W-1), which is
    // exactly its magnitude when read as unsigned.
    always_comb begin
        re  = word[MSB-1:W];
        im  = word[W-1:0];
        a   = re[W-1] ? W'(-re) : re;
        b   = im[W-1] ? W'(-im) : im;
        hi  = (a > b) ? a : b;
        lo  = (a > b) ? b : a;
        mag = hi + (lo >> 1);
    end

endmodule

// File: rtl/fft_mag_streamer.sv
// Snapshots the FFT result bus on each finish rising edge and streams the
// first BINS bin magnitudes over a valid/ready handshake.
// Ports: clk, rst_n; fft_data/fft_finish from the core; out_data, out_bin,
// out_valid, out_last to the sink with out_ready back; busy and overrun status.
module fft_mag_streamer
    import fft_mag_streamer_pkg::*;
#(
    parameter int N    = FFT_N,
    parameter int MSB  = FFT_MSB,
    parameter int BINS = N / 2,
    localparam int W   = MSB / 2,
    localparam int IW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [MSB*N-1:0] fft_data,
    input  logic           fft_finish,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_bin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           busy,
    output logic           overrun
);

    logic [0:0]     state;
    logic           finish_q;
    logic [MSB-1:0] frame [N];
    logic [IW-1:0]  idx;
    logic [IW-1:0]  nxt;
    logic           start;
    logic           last_nxt;
    logic [W-1:0]   mag;

    // While nothing is presented yet the current index is loaded; once a
    // bin is showing, the following bin is prepared for the transfer edge.
    always_comb begin
        start    = fft_finish & ~finish_q;
        nxt      = out_valid ? idx + 1'b1 : idx;
        last_nxt = (nxt == IW'(BINS - 1));
    end

    fft_mag_approx #(.MSB(MSB)) u_mag (
        .word (frame[nxt]),
        .mag  (mag)
    );

    // finish_q resets high so a finish level held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            finish_q  <= 1'b1;
            idx       <= '0;
            out_data  <= '0;
            out_bin   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                frame[k] <= '0;
            end
        end else begin
            finish_q <= fft_finish;
            overrun  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) begin
                            frame[k] <= fft_data[MSB*k +: MSB];
                        end
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= mag;
                        out_bin   <= nxt;
                        out_last  <= last_nxt;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx      <= nxt;
                            out_data <= mag;
                            out_bin  <= nxt;
                            out_last <= last_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
